// File: rtl/round_referee.sv
// Tug-of-War round controller: dark delay, lights, first-push arbitration.
// Ports: clk, rst, pb_l, pb_r, score[6:0] in; winrnd, right, leds_on out.
module round_referee #(
  parameter int MIN_DELAY = 1000,
  parameter int RAND_BITS = 12,
  parameter int CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pb_l,
  input  logic       pb_r,
  input  logic [6:0] score,
  output logic       winrnd,
  output logic       right,
  output logic       leds_on
);

  typedef enum logic [2:0] {
    IDLE,
    DARK,
    LIT,
    REPORT,
    OVER
  } state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, right-shifting Galois form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam logic [6:0] SC_WL  = 7'b1110000;
  localparam logic [6:0] SC_WR  = 7'b0000111;
  localparam logic [6:0] SC_ERR = 7'b1010101;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [15:0]      lfsr_q;
  logic [15:0]      lfsr_d;
  logic             pl_q;
  logic             pr_q;
  logic             winrnd_q;
  logic             right_q;
  logic             leds_q;

  logic             push_l;
  logic             push_r;
  logic             any_push;
  logic             who_right;
  logic             game_end;
  logic [CNT_W-1:0] delay_d;

  assign push_l   = pb_l & ~pl_q;
  assign push_r   = pb_r & ~pr_q;
  assign any_push = push_l | push_r;

  // Simultaneous pushes are settled by the LFSR coin.
  assign who_right = (push_l & push_r) ? lfsr_q[0] : push_r;

  assign game_end = (score == SC_WL) | (score == SC_WR) |
                    (score == SC_ERR);

  assign delay_d = CNT_W'(MIN_DELAY) +
                   CNT_W'(lfsr_q[RAND_BITS-1:0]);

  assign lfsr_d = {1'b0, lfsr_q[15:1]} ^
                  (lfsr_q[0] ? LFSR_TAPS : 16'h0000);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lfsr_q   <= LFSR_SEED;
      pl_q     <= 1'b1;
      pr_q     <= 1'b1;
      winrnd_q <= 1'b0;
      right_q  <= 1'b0;
      leds_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      pl_q   <= pb_l;
      pr_q   <= pb_r;
      unique case (state_q)
        IDLE: begin
          winrnd_q <= 1'b0;
          leds_q   <= 1'b0;
          if (game_end) begin
            right_q <= 1'b0;
            state_q <= OVER;
          end else if (!pb_l && !pb_r) begin
            cnt_q   <= delay_d;
            state_q <= DARK;
          end
        end
        DARK: begin
          if (any_push) begin
            right_q  <= who_right;
            winrnd_q <= 1'b1;
            state_q  <= REPORT;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
            if (cnt_q == CNT_W'(1)) begin
              leds_q  <= 1'b1;
              state_q <= LIT;
            end
          end
        end
        LIT: begin
          if (any_push) begin
            right_q  <= who_right;
            winrnd_q <= 1'b1;
            state_q  <= REPORT;
          end
        end
        REPORT: begin
          winrnd_q <= 1'b0;
          leds_q   <= 1'b0;
          state_q  <= IDLE;
        end
        OVER: begin
          winrnd_q <= 1'b0;
          right_q  <= 1'b0;
          leds_q   <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign winrnd  = winrnd_q;
  assign right   = right_q;
  assign leds_on = leds_q;

endmodule

// File: doc/round_referee.md
# round_referee

Round controller feeding the Tug-of-War `scorer`. It waits for both players to release their buttons, holds the lights dark for a pseudo-random delay, then lights them and arbitrates the first push. Each round ends with a one-cycle `winrnd` pulse, qualified by `right` and `leds_on`. After a winning or error score appears on the scorer's `score` bus, the block stops issuing rounds until reset.

## Interface
- `MIN_DELAY`, default 1000: minimum dark period in cycles; must be ≥ 1.
- `RAND_BITS`, default 12: number of LFSR bits added to `MIN_DELAY`.
- `CNT_W`, default 16: delay-counter width; must hold `MIN_DELAY + 2^RAND_BITS - 1`.

Ports:
- `clk`, input, 1: the single clock; all logic is on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `pb_l`, input, 1: left push button, active-high level, already debounced and synchronous to `clk`.
- `pb_r`, input, 1: right push button, same properties as `pb_l`.
- `score`, input, 7: scorer output, `[L3 L2 L1 N R1 R2 R3]`.
- `winrnd`, output, 1: one-cycle pulse marking that a round was decided.
- `right`, output, 1: 1 if the right player pushed first; valid while `winrnd` is 1.
- `leds_on`, output, 1: lights lit; also qualifies the push as proper (1) or a jump (0).

## Operation
- **Reset values:** `winrnd`=0, `right`=0, `leds_on`=0, state IDLE, counter 0, LFSR 16'hACE1, `pl_q`=1, `pr_q`=1.
- **Reset mid-round:** reset at any point returns the block to these values. Because `pl_q`/`pr_q` reset to 1, a button held through reset never counts as a push.
- **Push edges:** the block registers each button's previous value (`pl_q`, `pr_q`). `push_l = pb_l & ~pl_q`; `push_r = pb_r & ~pr_q`.
- **LFSR:** 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. It is free-running (steps every cycle from reset) and never reaches 0.
- **States:** IDLE, DARK, LIT, REPORT, OVER. All outputs are registered.
- **IDLE:**
  - Check `score` first. If it is 7'b1110000 (WL), 7'b0000111 (WR) or 7'b1010101 (error), go to OVER.
  - Otherwise, if `pb_l`=0 and `pb_r`=0, load counter with D = `MIN_DELAY` + `lfsr[RAND_BITS-1:0]` (zero-extended to `CNT_W`) and go to DARK.
  - Otherwise stay in IDLE.
- **DARK:**
  - A push edge on either button latches `right` (see tie rule) and moves to REPORT. `leds_on` stays 0.
  - Otherwise the counter decrements; when the counter equals 1, move to LIT and set `leds_on`=1.
- **LIT:** `leds_on`=1. The first push edge latches `right` and moves to REPORT. There is no timeout.
- **Tie rule:** if `push_l` and `push_r` occur in the same cycle, `right` = `lfsr[0]`.
- **REPORT:** `winrnd`=1 for exactly this cycle. `right` and `leds_on` hold the values they had at detection. Next state is IDLE, where `leds_on`, `winrnd`=0.
- **OVER:** all outputs 0; the block ignores buttons until `rst`.
- **Ignored pushes:** push edges in IDLE, REPORT and OVER are ignored. A button still held after REPORT keeps the block in IDLE.

## Timing
- The push edge is sampled in cycle N. The state is REPORT in cycle N+1, with `winrnd`, `right` and `leds_on` all valid in N+1.
- With no push, DARK lasts exactly D cycles. `leds_on` rises in the first cycle after the last DARK cycle.
- `score` is checked in IDLE, not in REPORT. The scorer updates `score` at the edge ending REPORT, so the value seen in the first IDLE cycle already reflects the round.
- Minimum round period is D + 3 cycles: IDLE, D × DARK, LIT, REPORT.
- `winrnd` is never high in two consecutive cycles.

## Test plan
- **Reset check:** assert `rst` with `pb_l`=1 held. After release, outputs are 0 and no `winrnd` occurs until `pb_l` drops and a new edge arrives.
- **Proper right push:** with `MIN_DELAY`=4, `RAND_BITS`=2 and score N, wait for `leds_on`=1, then raise `pb_r`.
  - The next cycle has `winrnd`=1, `right`=1, `leds_on`=1.
  - The cycle after that has `winrnd`=0, `leds_on`=0.
- **Left jump:** raise `pb_l` during DARK. The next cycle has `winrnd`=1, `right`=0, `leds_on`=0. `leds_on` never rose during the round.
- **Dark-period bounds:** over 200 rounds, the DARK length measured in cycles always lies in [`MIN_DELAY`, `MIN_DELAY` + 2^`RAND_BITS` − 1] and takes more than one distinct value.
- **Tie:** raise `pb_l` and `pb_r` in the same cycle during LIT. Exactly one `winrnd` pulse occurs, with `right` equal to the `lfsr[0]` sampled in the detection cycle.
- **Game over:** drive `score`=7'b0000111 after a REPORT. The block enters OVER and produces no further `winrnd` or `leds_on` despite button toggling, until `rst`.
